// File: rtl/pomo_sequencer.sv
// Pomodoro phase controller: sequences WORK / SHORT / LONG phases and counts
// each one down in BCD mm:ss from a 1 Hz tick prescaled from clk.
module pomo_sequencer #(
  parameter int CLK_HZ          = 12000000,
  parameter int WORK_MIN        = 25,
  parameter int SHORT_MIN       = 5,
  parameter int LONG_MIN        = 15,
  parameter int CYCLES_PER_LONG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic       skip_pulse,
  input  logic       clear_pulse,
  output logic [7:0] mins_bcd,
  output logic [7:0] secs_bcd,
  output logic [1:0] phase,
  output logic       running,
  output logic       phase_done,
  output logic [2:0] work_cnt
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

  function automatic logic [7:0] to_bcd(input int n);
    to_bcd = {4'(n / 10), 4'(n % 10)};
  endfunction

  localparam logic [7:0] WORK_BCD  = to_bcd(WORK_MIN);
  localparam logic [7:0] SHORT_BCD = to_bcd(SHORT_MIN);
  localparam logic [7:0] LONG_BCD  = to_bcd(LONG_MIN);
  localparam logic [2:0] CPL       = 3'(CYCLES_PER_LONG);

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_WORK  = 2'b01;
  localparam logic [1:0] PH_SHORT = 2'b10;
  localparam logic [1:0] PH_LONG  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t          state_q;
  logic [1:0]      phase_q;
  logic [7:0]      mins_q, secs_q;
  logic [PW-1:0]   presc_q;
  logic [2:0]      work_cnt_q;
  logic            done_q, running_q;

  logic [PW-1:0]   presc_d;
  logic [7:0]      mins_d, secs_d;
  logic [1:0]      end_phase_d;
  logic [7:0]      end_mins_d;
  logic [2:0]      end_wc_d, wc_inc;
  logic            tick, expire, do_end;

  assign tick    = (state_q == S_RUN) && (presc_q == PRESC_TC);
  assign presc_d = tick ? '0 : presc_q + PW'(1);
  assign expire  = (mins_q == 8'h00) && (secs_q == 8'h01);
  assign do_end  = (state_q != S_IDLE) &&
                   (skip_pulse || (!start_pulse && tick && expire));

  // Digit-wise BCD decrement with borrow chain secs units -> tens -> minutes.
  always_comb begin
    secs_d = secs_q;
    mins_d = mins_q;
    if (secs_q[3:0] != 4'd0) begin
      secs_d[3:0] = secs_q[3:0] - 4'd1;
    end else begin
      secs_d[3:0] = 4'd9;
      if (secs_q[7:4] != 4'd0) begin
        secs_d[7:4] = secs_q[7:4] - 4'd1;
      end else begin
        secs_d[7:4] = 4'd5;
        if (mins_q[3:0] != 4'd0) begin
          mins_d[3:0] = mins_q[3:0] - 4'd1;
        end else begin
          mins_d[3:0] = 4'd9;
          mins_d[7:4] = mins_q[7:4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    wc_inc      = work_cnt_q + 3'd1;
    end_phase_d = PH_WORK;
    end_mins_d  = WORK_BCD;
    end_wc_d    = work_cnt_q;
    if (phase_q == PH_WORK) begin
      if (wc_inc == CPL) begin
        end_phase_d = PH_LONG;
        end_mins_d  = LONG_BCD;
        end_wc_d    = 3'd0;
      end else begin
        end_phase_d = PH_SHORT;
        end_mins_d  = SHORT_BCD;
        end_wc_d    = wc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_pulse) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_IDLE;
      mins_q     <= WORK_BCD;
      secs_q     <= 8'h00;
      presc_q    <= '0;
      work_cnt_q <= 3'd0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start_pulse) begin
          state_q   <= S_RUN;
          running_q <= 1'b1;
          phase_q   <= PH_WORK;
          mins_q    <= WORK_BCD;
          secs_q    <= 8'h00;
          presc_q   <= '0;
        end
      end else if (do_end) begin
        done_q     <= 1'b1;
        state_q    <= S_PAUSE;
        running_q  <= 1'b0;
        presc_q    <= '0;
        phase_q    <= end_phase_d;
        mins_q     <= end_mins_d;
        secs_q     <= 8'h00;
        work_cnt_q <= end_wc_d;
      end else begin
        // The prescaler keeps wrapping even when start suppresses the tick.
        if (state_q == S_RUN) presc_q <= presc_d;
        if (start_pulse) begin
          state_q   <= (state_q == S_RUN) ? S_PAUSE : S_RUN;
          running_q <= (state_q != S_RUN);
        end else if (tick) begin
          secs_q <= secs_d;
          mins_q <= mins_d;
        end
      end
    end
  end

  assign mins_bcd   = mins_q;
  assign secs_bcd   = secs_q;
  assign phase      = phase_q;
  assign running    = running_q;
  assign phase_done = done_q;
  assign work_cnt   = work_cnt_q;

endmodule

// File: tb/tb_pomo_sequencer.sv
// Bench for pomo_sequencer: directed scenarios plus random pulses, checked
// against an integer-seconds reference model.
module tb_pomo_sequencer;
  localparam int CLK_HZ = 4, WORK_MIN = 1, SHORT_MIN = 10, LONG_MIN = 2, CPL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0, start_pulse = 1'b0, skip_pulse = 1'b0, clear_pulse = 1'b0;
  logic [7:0] mins_bcd, secs_bcd;
  logic [1:0] phase;
  logic running, phase_done;
  logic [2:0] work_cnt;

  int vectors = 0, miscompares = 0;

  // Model: state 0 idle / 1 run / 2 pause, remaining time in plain seconds.
  int m_state, m_phase, m_rem, m_presc, m_wc;
  bit m_done;

  pomo_sequencer #(.CLK_HZ(CLK_HZ), .WORK_MIN(WORK_MIN), .SHORT_MIN(SHORT_MIN),
                   .LONG_MIN(LONG_MIN), .CYCLES_PER_LONG(CPL)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .skip_pulse(skip_pulse),
    .clear_pulse(clear_pulse), .mins_bcd(mins_bcd), .secs_bcd(secs_bcd),
    .phase(phase), .running(running), .phase_done(phase_done), .work_cnt(work_cnt));

  always #5 clk = ~clk;

  wire [22:0] obs  = {mins_bcd, secs_bcd, phase, running, phase_done, work_cnt};
  wire [15:0] disp = {mins_bcd, secs_bcd};
  localparam logic [22:0] RESET_VEC = {8'h01, 8'h00, 2'b00, 1'b0, 1'b0, 3'd0};

  function automatic logic [22:0] exp_vec();
    int m, s;
    m = m_rem / 60;
    s = m_rem % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 2'(m_phase),
            (m_state == 1), m_done, 3'(m_wc)};
  endfunction

  task automatic model_phase_end();
    m_done  = 1;
    m_state = 2;
    m_presc = 0;
    if (m_phase == 1) begin
      m_wc++;
      if (m_wc == CPL) begin m_phase = 3; m_rem = LONG_MIN * 60; m_wc = 0; end
      else begin m_phase = 2; m_rem = SHORT_MIN * 60; end
    end else begin
      m_phase = 1;
      m_rem   = WORK_MIN * 60;
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit sk, input bit cl);
    bit tick;
    m_done = 0;
    if (r || cl) begin
      m_state = 0; m_phase = 0; m_rem = WORK_MIN * 60; m_presc = 0; m_wc = 0;
    end else if (m_state == 0) begin
      if (st) begin m_state = 1; m_phase = 1; m_rem = WORK_MIN * 60; m_presc = 0; end
    end else if (sk) begin
      model_phase_end();
    end else begin
      tick = (m_state == 1) && (m_presc == CLK_HZ - 1);
      if (m_state == 1) m_presc = (m_presc + 1) % CLK_HZ;
      if (st) m_state = (m_state == 1) ? 2 : 1;
      else if (tick) begin
        if (m_rem == 1) model_phase_end();
        else m_rem--;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit st, input bit sk, input bit cl);
    rst = r; start_pulse = st; skip_pulse = sk; clear_pulse = cl;
    @(posedge clk);
    model_step(r, st, sk, cl);
    #1;
    rst = 0; start_pulse = 0; skip_pulse = 0; clear_pulse = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    vectors++;
    if (obs !== RESET_VEC) begin
      miscompares++; $display("FAIL reset: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_work_expiry();
    cycle(0, 1, 0, 0);
    vectors++;
    if (obs !== {8'h01, 8'h00, 2'b01, 1'b1, 1'b0, 3'd0}) begin
      miscompares++; $display("FAIL start: got %h want 0100 run work", obs);
    end
    for (int i = 1; i <= 240; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL work_run cyc %0d: got %h want %h", i, obs, exp_vec());
      end
      if (i == 4) begin
        vectors++;
        if (disp !== 16'h0059) begin
          miscompares++; $display("FAIL first_tick: got %h want 0059", disp);
        end
      end
    end
    vectors++;
    if (obs !== {8'h10, 8'h00, 2'b10, 1'b0, 1'b1, 3'd1}) begin
      miscompares++; $display("FAIL work_expiry: got %h want 1000 short done wc1", obs);
    end
  endtask

  task automatic test_long_break();
    logic [15:0] prev;
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    vectors++;
    if (obs !== {8'h02, 8'h00, 2'b11, 1'b0, 1'b1, 3'd0}) begin
      miscompares++; $display("FAIL long_entry: got %h want 0200 long done wc0", obs);
    end
    cycle(0, 1, 0, 0);
    prev = disp;
    for (int i = 1; i <= 480; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL long_run cyc %0d: got %h want %h", i, obs, exp_vec());
      end
      vectors++;
      if (disp[3:0] > 9 || disp[7:4] > 5 || disp[11:8] > 9 || disp[15:12] > 9 ||
          disp == 16'h0000) begin
        miscompares++; $display("FAIL bcd_digits cyc %0d: got %h want legal nonzero", i, disp);
      end
      if (prev == 16'h0100 && disp != prev) begin
        vectors++;
        if (disp !== 16'h0059) begin
          miscompares++; $display("FAIL min_borrow: got %h want 0059", disp);
        end
      end
      if (prev == 16'h0110 && disp != prev) begin
        vectors++;
        if (disp !== 16'h0109) begin
          miscompares++; $display("FAIL tens_borrow: got %h want 0109", disp);
        end
      end
      prev = disp;
    end
    vectors++;
    if (obs !== {8'h01, 8'h00, 2'b01, 1'b0, 1'b1, 3'd0}) begin
      miscompares++; $display("FAIL long_expiry: got %h want 0100 work done", obs);
    end
  endtask

  task automatic test_short_borrow();
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 0);
    vectors++;
    if (obs !== exp_vec() || disp !== 16'h0959) begin
      miscompares++; $display("FAIL ten_borrow: got %h want 0959 (%h)", disp, exp_vec());
    end
  endtask

  task automatic test_pause();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (obs !== exp_vec() || disp !== 16'h0959 || running !== 1'b0) begin
        miscompares++; $display("FAIL pause_hold cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    cycle(0, 1, 0, 0);
    vectors++;
    if (disp !== 16'h0959 || running !== 1'b1) begin
      miscompares++; $display("FAIL resume: got %h run %b want 0959 run 1", disp, running);
    end
    cycle(0, 0, 0, 0);
    vectors++;
    if (obs !== exp_vec() || disp !== 16'h0958) begin
      miscompares++; $display("FAIL resume_tick: got %h want 0958", disp);
    end
  endtask

  task automatic test_skip_start();
    cycle(0, 1, 1, 0);
    vectors++;
    if (obs !== {8'h01, 8'h00, 2'b01, 1'b0, 1'b1, 3'd1}) begin
      miscompares++; $display("FAIL skip_wins: got %h want 0100 work paused done wc1", obs);
    end
  endtask

  task automatic test_clear_tick();
    int n = 0;
    cycle(0, 1, 0, 0);
    while (m_presc != CLK_HZ - 1 && n < 8) begin cycle(0, 0, 0, 0); n++; end
    vectors++;
    if (m_presc != CLK_HZ - 1 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL pre_clear: got %h want %h presc %0d", obs, exp_vec(), m_presc);
    end
    cycle(0, 0, 0, 1);
    vectors++;
    if (obs !== RESET_VEC) begin
      miscompares++; $display("FAIL clear_tick: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_rst_mid_run();
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    vectors++;
    if (obs !== RESET_VEC) begin
      miscompares++; $display("FAIL rst_mid_run: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_skip_idle();
    cycle(0, 0, 1, 0);
    vectors++;
    if (obs !== RESET_VEC) begin
      miscompares++; $display("FAIL skip_idle: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_random();
    bit r, st, sk, cl;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 999) < 1);
      cl = ($urandom_range(0, 999) < 1);
      sk = ($urandom_range(0, 999) < 3);
      st = ($urandom_range(0, 999) < 10);
      cycle(r, st, sk, cl);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    m_state = 0; m_phase = 0; m_rem = WORK_MIN * 60; m_presc = 0; m_wc = 0; m_done = 0;
    #2;
    test_reset();
    test_work_expiry();
    test_long_break();
    test_short_borrow();
    test_pause();
    test_skip_start();
    test_clear_tick();
    test_rst_mid_run();
    test_skip_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
